// File: rtl/fifo_ctrl_pkg.sv
// Shared sizing for the FIFO controller and its occupancy decoder.
package fifo_ctrl_pkg;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned ADDR_N = 3;
    localparam int unsigned DEPTH  = 2 ** ADDR_N;
    localparam int unsigned CNT_W  = ADDR_N + 1;
endpackage

// File: rtl/fifo_valid_decode.sv
// Combinational head/count to occupancy bitmap: bit i set iff i is in [head, head+count) mod depth.
module fifo_valid_decode #(
    parameter int unsigned addressN = 3
) (
    input  logic [addressN-1:0]      head,
    input  logic [addressN:0]        count,
    output logic [2**addressN-1:0]   valid
);
    localparam int unsigned depth = 2 ** addressN;

    logic [addressN-1:0] offset;

    // Distance of each slot from head, modulo depth, compared against occupancy.
    always_comb begin
        valid  = '0;
        offset = '0;
        for (int unsigned i = 0; i < depth; i++) begin
            offset   = addressN'(i) - head;
            valid[i] = {1'b0, offset} < count;
        end
    end
endmodule

// File: rtl/fifo_ctrl.sv
// Circular-FIFO sequencer for the external register file: pointers, occupancy, dequeue data.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned dataWidth = DATA_W,
    parameter int unsigned addressN  = ADDR_N
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq,
    input  logic                     deq,
    input  logic [dataWidth-1:0]     din,
    output logic [dataWidth-1:0]     dout,
    output logic                     dout_valid,
    output logic                     full,
    output logic                     empty,
    output logic [addressN:0]        count,
    output logic [2**addressN-1:0]   valid,
    output logic [addressN-1:0]      wa,
    output logic [dataWidth-1:0]     wd,
    output logic                     we,
    output logic [addressN-1:0]      ra0,
    input  logic [dataWidth-1:0]     rd0
);
    localparam int unsigned depth = 2 ** addressN;
    localparam int unsigned cnt_w = addressN + 1;

    logic [addressN-1:0] head;
    logic [addressN-1:0] tail;
    logic                accept_enq;
    logic                accept_deq;

    assign full  = (count == cnt_w'(depth));
    assign empty = (count == '0);

    // Enqueue on a full queue is allowed only when a dequeue frees the slot in the same edge.
    assign accept_enq = enq & (~full | deq);
    assign accept_deq = deq & ~empty;

    assign we  = accept_enq & ~rst;
    assign wa  = tail;
    assign wd  = din;
    assign ra0 = head;

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= accept_deq;
            if (accept_enq) begin
                tail <= tail + addressN'(1);
            end
            if (accept_deq) begin
                dout <= rd0;
                head <= head + addressN'(1);
            end
            case ({accept_enq, accept_deq})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
        end
    end

    fifo_valid_decode #(
        .addressN (addressN)
    ) u_valid_decode (
        .head  (head),
        .count (count),
        .valid (valid)
    );
endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a behavioural register file on the write/read ports.
module tb_fifo_ctrl;
    logic       clk;
    logic       rst;
    logic       enq;
    logic       deq;
    logic [3:0] din;
    logic [3:0] dout;
    logic       dout_valid;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic [7:0] valid;
    logic [2:0] wa;
    logic [3:0] wd;
    logic       we;
    logic [2:0] ra0;
    logic [3:0] rd0;

    logic [3:0] mem [8];

    int total = 0;
    int bad   = 0;

    fifo_ctrl #(.dataWidth(4), .addressN(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .enq        (enq),
        .deq        (deq),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .valid      (valid),
        .wa         (wa),
        .wd         (wd),
        .we         (we),
        .ra0        (ra0),
        .rd0        (rd0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: synchronous write, combinational read.
    always @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end
    assign rd0 = mem[ra0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic d, input logic [3:0] x);
        rst = r;
        enq = e;
        deq = d;
        din = x;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 4'h0;
        drive(1'b1, 1'b0, 1'b0, 4'h0);

        // 1: reset then idle
        check("rst_we", 32'(we), 32'd0);
        tick();
        check("rst_we_c1", 32'(we), 32'd0);
        tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_valid", 32'(valid), 32'h00);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_dv", 32'(dout_valid), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        check("idle_we", 32'(we), 32'd0);
        tick();

        // 2: fill with 1..8
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b1, 1'b0, 4'(i));
            check("fill_we", 32'(we), 32'd1);
            check("fill_wa", 32'(wa), 32'(i - 1));
            check("fill_wd", 32'(wd), 32'(i));
            tick();
            check("fill_count", 32'(count), 32'(i));
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_valid", 32'(valid), 32'hFF);
        check("fill_tail_wrap", 32'(wa), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 4'd9);
        check("ovf_we", 32'(we), 32'd0);
        tick();
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_wa", 32'(wa), 32'd0);
        check("ovf_dv", 32'(dout_valid), 32'd0);

        // 3: drain
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b0, 1'b1, 4'h0);
            check("drain_ra0", 32'(ra0), 32'(i - 1));
            tick();
            check("drain_dout", 32'(dout), 32'(i));
            check("drain_dv", 32'(dout_valid), 32'd1);
            check("drain_count", 32'(count), 32'(8 - i));
        end
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_valid", 32'(valid), 32'h00);
        drive(1'b0, 1'b0, 1'b1, 4'h0);
        tick();
        check("udf_dv", 32'(dout_valid), 32'd0);
        check("udf_dout", 32'(dout), 32'd8);
        check("udf_count", 32'(count), 32'd0);

        // 4: wrap-around with simultaneous requests while full
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 4'(4'hA + i));
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b1, 4'h0);
            tick();
            check("wrap_deq_dout", 32'(dout), 32'(4'hA + i));
        end
        check("wrap_head", 32'(ra0), 32'd2);
        check("wrap_tail", 32'(wa), 32'd3);
        check("wrap_valid1", 32'(valid), 32'h04);
        for (int i = 1; i <= 7; i++) begin
            drive(1'b0, 1'b1, 1'b0, 4'(i));
            tick();
        end
        check("wrap_full", 32'(full), 32'd1);
        check("wrap_tail2", 32'(wa), 32'd2);
        check("wrap_validf", 32'(valid), 32'hFF);
        drive(1'b0, 1'b1, 1'b1, 4'hF);
        check("both_full_we", 32'(we), 32'd1);
        tick();
        check("both_full_dout", 32'(dout), 32'hC);
        check("both_full_dv", 32'(dout_valid), 32'd1);
        check("both_full_count", 32'(count), 32'd8);
        check("both_full_ra0", 32'(ra0), 32'd3);
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b0, 1'b1, 4'h0);
            tick();
            check("wrap_drain", 32'(dout), (i == 8) ? 32'hF : 32'(i));
        end
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        tick();
        check("idle_dv", 32'(dout_valid), 32'd0);
        check("wrap_empty", 32'(empty), 32'd1);

        // 5: simultaneous on empty, then simultaneous at count 1
        drive(1'b0, 1'b1, 1'b1, 4'd5);
        tick();
        check("both_empty_count", 32'(count), 32'd1);
        check("both_empty_dv", 32'(dout_valid), 32'd0);
        check("both_empty_dout", 32'(dout), 32'hF);
        drive(1'b0, 1'b1, 1'b1, 4'd6);
        tick();
        check("both_mid_dout", 32'(dout), 32'd5);
        check("both_mid_count", 32'(count), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 4'h0);
        tick();
        check("last_dout", 32'(dout), 32'd6);
        check("last_empty", 32'(empty), 32'd1);

        // 6: reset mid-operation
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 4'(i));
            tick();
        end
        check("pre_rst_count", 32'(count), 32'd4);
        drive(1'b1, 1'b1, 1'b0, 4'h7);
        check("mid_rst_we", 32'(we), 32'd0);
        tick();
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_wa", 32'(wa), 32'd0);
        check("mid_rst_ra0", 32'(ra0), 32'd0);
        check("mid_rst_valid", 32'(valid), 32'h00);
        check("mid_rst_dout", 32'(dout), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
